// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
//   - op encodings carried on the op port
//   - FSM state encodings used by mult_div_unit
package mult_div_unit_pkg;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  // Signed variants are the even encodings of the MD group.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/mult_div_unit_datapath.sv
// Iterative datapath for mult_div_unit: works on unsigned magnitudes only.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture a_mag/b_mag and clear the accumulator
//   step       : perform one shift-add (multiply) or restoring step (divide)
//   is_div     : selects divide behaviour for load and step
//   a_mag      : multiplicand / dividend magnitude
//   b_mag      : multiplier / divisor magnitude
//   acc        : multiply -> 2W-bit product; divide -> {remainder, quotient}
module mult_div_unit_datapath #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      step,
  input  logic                      is_div,
  input  logic [DATA_WIDTH-1:0]     a_mag,
  input  logic [DATA_WIDTH-1:0]     b_mag,
  output logic [2*DATA_WIDTH-1:0]   acc
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;

  logic [W2-1:0] acc_q, acc_d;
  // Multiply: multiplicand shifted left each step. Divide: low half holds the divisor.
  logic [W2-1:0] mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;

  logic [W2-1:0] shifted;
  logic [W-1:0]  upper;
  logic [W-1:0]  diff;
  logic          take;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    shifted  = {acc_q[W2-2:0], 1'b0};
    upper    = shifted[W2-1:W];
    diff     = upper - mcand_q[W-1:0];
    // The bit shifted out of the top means the partial remainder is >= 2^W,
    // which always exceeds the divisor; diff is still correct modulo 2^W.
    take     = acc_q[W2-1] || (upper >= mcand_q[W-1:0]);

    if (load) begin
      acc_d    = is_div ? {{W{1'b0}}, a_mag} : '0;
      mcand_d  = is_div ? {{W{1'b0}}, b_mag} : {{W{1'b0}}, a_mag};
      mplier_d = b_mag;
    end else if (step) begin
      if (is_div) begin
        acc_d = take ? {diff, shifted[W-1:1], 1'b1} : shifted;
      end else begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = {mcand_q[W2-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (EX stage).
//   clk, reset : clock, synchronous active-high reset
//   start      : request, accepted only while idle and not flushed
//   op         : MULT/MULTU/DIV/DIVU/MTHI/MTLO; 11x ignored
//   operand_a  : rs value (multiplicand, dividend, MTHI/MTLO source)
//   operand_b  : rt value (multiplier, divisor)
//   flush      : cancel the in-flight op; HI/LO untouched
//   busy       : op in flight
//   done       : one-cycle pulse when a MULT*/DIV* result lands in HI/LO
//   hi, lo     : HI and LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W        = DATA_WIDTH;
  localparam int unsigned MdIter   = DATA_WIDTH;
  localparam int unsigned CountW   = (MdIter > 1) ? $clog2(MdIter) : 1;
  localparam logic [CountW-1:0] LastCount = CountW'(MdIter - 1);

  logic [1:0]        state_q, state_d;
  logic [CountW-1:0] count_q;
  logic              is_div_q, signed_q, sign_a_q, sign_b_q, b_zero_q;
  logic [W-1:0]      a_raw_q;
  logic [W-1:0]      hi_q, lo_q;
  logic              done_q;

  logic          idle, accept, is_mul_op, is_div_op, op_signed, a_neg, b_neg;
  logic          load, step, dp_is_div;
  logic [W-1:0]  a_mag, b_mag;
  logic [2*W-1:0] acc, prod;
  logic [W-1:0]  quot, rem, res_hi, res_lo;

  assign idle      = (state_q == StIdle);
  assign accept    = idle && start && !flush;
  assign is_mul_op = (op == OpMult) || (op == OpMultu);
  assign is_div_op = (op == OpDiv) || (op == OpDivu);
  assign op_signed = op_is_signed(op);
  assign a_neg     = op_signed && operand_a[W-1];
  assign b_neg     = op_signed && operand_b[W-1];
  assign a_mag     = a_neg ? ('0 - operand_a) : operand_a;
  assign b_mag     = b_neg ? ('0 - operand_b) : operand_b;
  assign load      = accept && (is_mul_op || is_div_op);
  assign step      = (state_q == StMul) || (state_q == StDiv);
  assign dp_is_div = load ? is_div_op : is_div_q;

  mult_div_unit_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (dp_is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = is_div_op ? StDiv : StMul;
        end
      end
      StMul, StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else if (count_q == LastCount) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sign fix-up on the magnitude result.
  always_comb begin
    prod = acc;
    quot = acc[W-1:0];
    rem  = acc[2*W-1:W];
    if (signed_q && (sign_a_q ^ sign_b_q)) begin
      prod = '0 - acc;
      quot = '0 - acc[W-1:0];
    end
    if (signed_q && sign_a_q) begin
      rem = '0 - acc[2*W-1:W];
    end
    if (is_div_q) begin
      res_hi = b_zero_q ? a_raw_q : rem;
      res_lo = b_zero_q ? '1 : quot;
    end else begin
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      is_div_q <= 1'b0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (load) begin
        count_q  <= '0;
        is_div_q <= is_div_op;
        signed_q <= op_signed;
        sign_a_q <= a_neg;
        sign_b_q <= b_neg;
        b_zero_q <= (operand_b == '0);
        a_raw_q  <= operand_a;
      end else if (step) begin
        count_q <= count_q + 1'b1;
      end
      if (accept && (op == OpMthi)) begin
        hi_q <= operand_a;
      end
      if (accept && (op == OpMtlo)) begin
        lo_q <= operand_a;
      end
      // A flush landing on the FIX cycle still discards the result.
      if ((state_q == StFix) && !flush) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end
    end
  end

  assign busy = !idle;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    tick();
    start = 1'b0;
  endtask

  // Run a MD op to completion; reports busy cycles, done pulses and HI/LO in the done cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int ncyc, output int pulses,
                       output logic [31:0] h, output logic [31:0] l);
    issue(o, a, b);
    ncyc = 0; pulses = 0;
    while (busy === 1'b1 && ncyc < 100) begin
      ncyc++;
      if (done === 1'b1) pulses++;
      tick();
    end
    h = hi; l = lo;
    if (done === 1'b1) pulses++;
    tick();
    if (done === 1'b1) pulses++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_mult();
    int n, p; logic [31:0] h, l;
    do_op(OP_MULT, 32'hFFFFFFFD, 32'd7, n, p, h, l);
    checks++; if (n !== 33) begin errors++; $display("FAIL mult_latency got %0d want 33", n); end
    checks++; if (p !== 1) begin errors++; $display("FAIL mult_done_pulses got %0d want 1", p); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", h); end
    checks++; if (l !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", l); end
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n, p, h, l);
    checks++; if (h !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", h); end
    checks++; if (l !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", l); end
    do_op(OP_MULT, 32'h80000000, 32'h80000000, n, p, h, l);
    checks++; if ({h, l} !== 64'h40000000_00000000) begin
      errors++; $display("FAIL mult_minmin got %h%h want 4000000000000000", h, l);
    end
  endtask

  task automatic test_div();
    int n, p; logic [31:0] h, l;
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, n, p, h, l);
    checks++; if (n !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", n); end
    checks++; if (l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", l); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", h); end
    do_op(OP_DIV, 32'd7, 32'hFFFFFFFE, n, p, h, l);
    checks++; if ({h, l} !== {32'd1, 32'hFFFFFFFD}) begin
      errors++; $display("FAIL div_negdivisor got %h:%h want 00000001:fffffffd", h, l);
    end
    do_op(OP_DIVU, 32'd7, 32'd0, n, p, h, l);
    checks++; if (l !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero_lo got %h want ffffffff", l); end
    checks++; if (h !== 32'd7) begin errors++; $display("FAIL divu_zero_hi got %h want 7", h); end
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd0, n, p, h, l);
    checks++; if ({h, l} !== {32'hFFFFFFF9, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL div_zero got %h:%h want fffffff9:ffffffff", h, l);
    end
    do_op(OP_DIVU, 32'hFFFFFFFF, 32'd10, n, p, h, l);
    checks++; if ({h, l} !== {32'd5, 32'h19999999}) begin
      errors++; $display("FAIL divu_big got %h:%h want 00000005:19999999", h, l);
    end
  endtask

  task automatic test_div_overflow_and_mt();
    int n, p; int busy_seen; logic [31:0] h, l;
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, n, p, h, l);
    checks++; if (l !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", l); end
    checks++; if (h !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", h); end
    busy_seen = 0;
    start = 1'b1; op = OP_MTHI; operand_a = 32'h1234; operand_b = 32'h0;
    tick();
    if (busy !== 1'b0 || done !== 1'b0) busy_seen++;
    op = OP_MTLO; operand_a = 32'h5678;
    tick();
    start = 1'b0;
    if (busy !== 1'b0 || done !== 1'b0) busy_seen++;
    tick();
    if (busy !== 1'b0 || done !== 1'b0) busy_seen++;
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL mt_busy_or_done got %0d want 0", busy_seen); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h want 1234", hi); end
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo got %h want 5678", lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    // Busy cycle 5: a new MULT must be ignored.
    issue(OP_MULT, 32'd3, 32'd3);
    n = 5;
    while (busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", n); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %0b want 1", done); end
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin
      errors++; $display("FAIL b2b_divu got %h:%h want 00000002:0000000e", hi, lo);
    end
    // Start in the done cycle is accepted.
    issue(OP_MULTU, 32'd3, 32'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_cycle_accept got %0b want 1", busy); end
    n = 1;
    while (busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if ({hi, lo} !== {32'd0, 32'd15}) begin
      errors++; $display("FAIL done_cycle_mult got %h:%h want 00000000:0000000f", hi, lo);
    end
    tick();
  endtask

  task automatic test_flush();
    int d;
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", busy); end
    d = 0;
    repeat (40) begin if (done !== 1'b0) d++; tick(); end
    checks++; if (d !== 0) begin errors++; $display("FAIL flush_done got %0d pulses want 0", d); end
    checks++; if ({hi, lo} !== {32'd0, 32'd15}) begin
      errors++; $display("FAIL flush_hilo got %h:%h want 00000000:0000000f", hi, lo);
    end
    // Flush and start together in IDLE: nothing accepted.
    flush = 1'b1;
    issue(OP_MTHI, 32'hAAAA, 32'd0);
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL flush_start_mthi got %h want 0", hi); end
    issue(OP_MULT, 32'd2, 32'd2);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_mult got %0b want 0", busy); end
    // Reserved ops do nothing.
    issue(3'b110, 32'hDEAD, 32'd1);
    issue(3'b111, 32'hBEEF, 32'd1);
    checks++; if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd15}) begin
      errors++; $display("FAIL reserved got busy=%0b %h:%h want 0 00000000:0000000f", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    issue(OP_MTHI, 32'h1111, 32'd0);
    issue(OP_MTLO, 32'h2222, 32'd0);
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_ctrl got busy=%0b done=%0b want 0 0", busy, done);
    end
    checks++; if ({hi, lo} !== 64'h0) begin
      errors++; $display("FAIL rst_mid_hilo got %h:%h want 0:0", hi, lo);
    end
    d = 0;
    repeat (40) begin if (done !== 1'b0 || busy !== 1'b0) d++; tick(); end
    checks++; if (d !== 0) begin errors++; $display("FAIL rst_mid_after got %0d active cycles want 0", d); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_overflow_and_mt();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
